// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// instruction classes, the registered decode bundle, ALU op codes, select
// encodings and opcode/funct constants.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5
  } state_e;

  // Instruction class, chooses the path taken after EXEC
  typedef enum logic [3:0] {
    K_ALU    = 4'd0,
    K_LOAD   = 4'd1,
    K_STORE  = 4'd2,
    K_BRANCH = 4'd3,
    K_J      = 4'd4,
    K_JAL    = 4'd5,
    K_JR     = 4'd6,
    K_JALR   = 4'd7,
    K_MDU    = 4'd8,
    K_MFHI   = 4'd9
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       bne;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_op;
    logic [4:0] alu_op;
    logic [2:0] length;
  } fields_t;

  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_NOR  = 5'b01001;
  localparam logic [4:0] ALU_SLL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_LUI  = 5'b01100;
  localparam logic [4:0] ALU_SRL  = 5'b01101;
  localparam logic [4:0] ALU_SLLV = 5'b01110;
  localparam logic [4:0] ALU_SRLV = 5'b01111;
  localparam logic [4:0] ALU_BGEZ = 5'b10000;
  localparam logic [4:0] ALU_BLTZ = 5'b10001;
  localparam logic [4:0] ALU_BLEZ = 5'b10010;
  localparam logic [4:0] ALU_BGTZ = 5'b10011;
  localparam logic [4:0] ALU_SRAV = 5'b10100;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [2:0] LEN_W  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_B  = 3'b010;
  localparam logic [2:0] LEN_HU = 3'b101;
  localparam logic [2:0] LEN_BU = 3'b110;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: maps opcode/funct/rt to the datapath
// field bundle and flags anything it does not recognise.
// Multiply/divide functs are accepted only when MC_CTRL_MDU_EN is defined.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output fields_t     fields,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign rt          = instr[20:16];
  assign unused_bits = ^{instr[25:21], instr[15:6]};

  // Decode table; defaults describe a harmless ALU op with nothing selected
  always_comb begin
    fields      = '0;
    fields.kind = K_ALU;
    illegal     = 1'b0;
    case (op)
      OP_RTYPE: begin
        fields.reg_dst = RDST_RD;
        case (funct)
          F_ADD, F_ADDU: fields.alu_op = ALU_ADD;
          F_SUB, F_SUBU: fields.alu_op = ALU_SUB;
          F_AND:         fields.alu_op = ALU_AND;
          F_OR:          fields.alu_op = ALU_OR;
          F_XOR:         fields.alu_op = ALU_XOR;
          F_NOR:         fields.alu_op = ALU_NOR;
          F_SLT:         fields.alu_op = ALU_SLT;
          F_SLTU:        fields.alu_op = ALU_SLTU;
          F_SLL: begin
            fields.alu_op    = ALU_SLL;
            fields.alu_src_a = 1'b1;
          end
          F_SRL: begin
            fields.alu_op    = ALU_SRL;
            fields.alu_src_a = 1'b1;
          end
          F_SRA: begin
            fields.alu_op    = ALU_SRA;
            fields.alu_src_a = 1'b1;
          end
          F_SLLV:        fields.alu_op = ALU_SLLV;
          F_SRLV:        fields.alu_op = ALU_SRLV;
          F_SRAV:        fields.alu_op = ALU_SRAV;
          F_JR: begin
            fields.kind    = K_JR;
            fields.reg_dst = RDST_RT;
          end
          F_JALR: begin
            fields.kind       = K_JALR;
            fields.mem_to_reg = M2R_PC;
          end
`ifdef MC_CTRL_MDU_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            fields.kind    = K_MDU;
            fields.reg_dst = RDST_RT;
          end
          F_MFHI, F_MFLO: fields.kind = K_MFHI;
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        fields.kind   = K_BRANCH;
        fields.ext_op = 1'b1;
        case (rt)
          RT_BLTZ: fields.alu_op = ALU_BLTZ;
          RT_BGEZ: fields.alu_op = ALU_BGEZ;
          default: illegal = 1'b1;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        fields.kind   = K_BRANCH;
        fields.bne    = (op == OP_BNE);
        fields.ext_op = 1'b1;
        fields.alu_op = ALU_SUB;
      end
      OP_BLEZ, OP_BGTZ: begin
        fields.kind   = K_BRANCH;
        fields.ext_op = 1'b1;
        fields.alu_op = (op == OP_BLEZ) ? ALU_BLEZ : ALU_BGTZ;
      end
      OP_J: fields.kind = K_J;
      OP_JAL: begin
        fields.kind       = K_JAL;
        fields.reg_dst    = RDST_RA;
        fields.mem_to_reg = M2R_PC;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        fields.alu_src_b = 1'b1;
        fields.ext_op    = 1'b1;
        case (op)
          OP_SLTI:  fields.alu_op = ALU_SLT;
          OP_SLTIU: fields.alu_op = ALU_SLTU;
          default:  fields.alu_op = ALU_ADD;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        fields.alu_src_b = 1'b1;
        case (op)
          OP_ANDI: fields.alu_op = ALU_AND;
          OP_ORI:  fields.alu_op = ALU_OR;
          OP_XORI: fields.alu_op = ALU_XOR;
          default: fields.alu_op = ALU_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        fields.kind       = K_LOAD;
        fields.alu_op     = ALU_ADD;
        fields.alu_src_b  = 1'b1;
        fields.ext_op     = 1'b1;
        fields.mem_to_reg = M2R_MEM;
        case (op)
          OP_LB:   fields.length = LEN_B;
          OP_LH:   fields.length = LEN_H;
          OP_LBU:  fields.length = LEN_BU;
          OP_LHU:  fields.length = LEN_HU;
          default: fields.length = LEN_W;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        fields.kind      = K_STORE;
        fields.alu_op    = ALU_ADD;
        fields.alu_src_b = 1'b1;
        fields.ext_op    = 1'b1;
        case (op)
          OP_SB:   fields.length = LEN_B;
          OP_SH:   fields.length = LEN_H;
          default: fields.length = LEN_W;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, the
// registered decode bundle and the memory-wait timeout counter.
// Optional MC_CTRL_MDU_EN adds the mdu_busy port and the MDU_WAIT state.
// Strobes are forced low while rst is high so the block is silent in reset.
module mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
`ifdef MC_CTRL_MDU_EN
  input  logic               mdu_busy,
`endif
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         npc_op,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         length,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e     state_q, state_n;
  fields_t    dec_fields, fq;
  logic       dec_illegal;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_inc;
  logic       mem_phase;
  logic       timeout;

  mc_ctrl_decode u_decode (
    .instr   (instr),
    .fields  (dec_fields),
    .illegal (dec_illegal)
  );

  assign cnt_inc   = wait_cnt + 8'd1;
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = mem_phase && !mem_ready && (cnt_inc == TIMEOUT_CNT);

  assign state      = state_q;
  assign reg_dst    = fq.reg_dst;
  assign mem_to_reg = fq.mem_to_reg;
  assign alu_src_a  = fq.alu_src_a;
  assign alu_src_b  = fq.alu_src_b;
  assign ext_op     = fq.ext_op;
  assign alu_op     = ALUOP_W'(fq.alu_op);
  assign length     = fq.length;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_n;
  end

  // Decoded fields are captured at the end of DECODE and held until the next one
  always_ff @(posedge clk) begin
    if (rst)                        fq <= '0;
    else if (state_q == S_DECODE)   fq <= dec_fields;
  end

  // Wait counter: restarts on every entry to FETCH/MEM, counts not-ready cycles
  always_ff @(posedge clk) begin
    if (rst)                                  wait_cnt <= 8'd0;
    else if (timeout || (state_n != state_q)) wait_cnt <= 8'd0;
    else if (mem_phase && !mem_ready)         wait_cnt <= cnt_inc;
  end

  // Next-state and strobe generation
  always_comb begin
    state_n   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    npc_op    = NPC_PC4;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          if (timeout) begin
            bus_err = 1'b1;
            state_n = S_FETCH;
          end else begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_n  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            illegal = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_EXEC;
          end
        end
        S_EXEC: begin
          case (fq.kind)
            K_BRANCH: begin
              npc_op   = NPC_BR;
              pc_write = fq.bne ? ~zero : zero;
              state_n  = S_FETCH;
            end
            K_J, K_JAL: begin
              npc_op   = NPC_J;
              pc_write = 1'b1;
              state_n  = (fq.kind == K_JAL) ? S_WB : S_FETCH;
            end
            K_JR, K_JALR: begin
              npc_op   = NPC_JR;
              pc_write = 1'b1;
              state_n  = (fq.kind == K_JALR) ? S_WB : S_FETCH;
            end
            K_LOAD, K_STORE: state_n = S_MEM;
`ifdef MC_CTRL_MDU_EN
            K_MDU, K_MFHI:   state_n = S_MDU_WAIT;
`endif
            default:         state_n = S_WB;
          endcase
        end
        S_MEM: begin
          if (timeout) begin
            bus_err = 1'b1;
            state_n = S_FETCH;
          end else if (fq.kind == K_STORE) begin
            mem_write = 1'b1;
            if (mem_ready) state_n = S_FETCH;
          end else begin
            mem_read = 1'b1;
            if (mem_ready) state_n = S_WB;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          state_n   = S_FETCH;
        end
        S_MDU_WAIT: begin
`ifdef MC_CTRL_MDU_EN
          if (!mdu_busy) state_n = (fq.kind == K_MFHI) ? S_WB : S_FETCH;
`else
          state_n = S_FETCH;
`endif
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It decodes the same instruction set into the same datapath control fields, and it stalls on a memory-ready handshake with a bounded timeout. It sits between the instruction register and the shared multi-cycle datapath, which has one memory port, one ALU and the register file.

## Interface
- `ALUOP_W`, 5: width of `alu_op`. Must be ≥5. Codes are zero-extended.
- `TIMEOUT`, 16: maximum cycles to wait for `mem_ready` in FETCH or MEM. Range 1..255.
- `clk` input 1: the only clock. All state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `instr` input 32: instruction register contents. Valid from DECODE onward.
- `zero` input 1: ALU condition flag. Sampled in EXEC.
- `mem_ready` input 1: memory access complete this cycle.
- `mdu_busy` input 1: multiply/divide unit busy. Exists only with `MDU_EN`.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` output 1 each: enable strobes.
- `reg_dst`, `mem_to_reg`, `npc_op` output 2 each: mux and next-PC selects. Encodings are unchanged from the single-cycle decoder.
- `alu_src_a`, `alu_src_b`, `ext_op` output 1 each: ALU operand selects and sign-extend.
- `alu_op` output `ALUOP_W`: ALU operation.
- `length` output 3: load/store size. 000 word, 001 half, 010 byte, 101 half unsigned, 110 byte unsigned.
- `illegal` output 1: one-cycle pulse on an undecodable instruction.
- `bus_err` output 1: one-cycle pulse on memory timeout.
- `state` output 3: current state, for debug.

## Operation
- States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5.
- FETCH
  - `mem_read`=1 and `ir_write`=`mem_ready`.
  - When `mem_ready` is high: `pc_write`=1 with `npc_op`=00 (PC+4), then go to DECODE.
- DECODE
  - Registers the decoded fields from `instr[31:26]` and `instr[5:0]`, or `instr[20:16]` for REGIMM.
  - Unknown opcode or funct: pulse `illegal`, go to FETCH. The PC has already advanced.
- EXEC
  - The ALU runs with the registered `alu_op` and source selects.
  - beq, bne, bgez, bltz, blez, bgtz: `pc_write`=`taken`, `npc_op`=01, then FETCH.
    - bne is taken on `~zero`. All others are taken on `zero`.
  - j: `pc_write`=1, `npc_op`=10, then FETCH.
  - jr: `pc_write`=1, `npc_op`=11, then FETCH.
  - jal and jalr additionally go to WB.
  - Loads and stores go to MEM.
  - All other instructions go to WB.
- MEM
  - Loads: `mem_read`=1. On `mem_ready`, go to WB.
  - Stores: `mem_write`=1. On `mem_ready`, go to FETCH.
  - `length` is valid throughout MEM.
- WB
  - `reg_write`=1 for exactly one cycle, then FETCH.
  - Write-back source: `mem_to_reg`=01 for loads, 10 for jal/jalr, 00 otherwise.
  - Destination: `reg_dst`=01 for R-type, 10 for jal, 00 otherwise.
- Timeout
  - An 8-bit wait counter clears on entry to FETCH and to MEM.
  - It increments each cycle that `mem_ready`=0.
  - When it reaches `TIMEOUT` with `mem_ready` still low: pulse `bus_err`, deassert strobes, go to FETCH without `pc_write`.
  - `mem_ready` arriving on the same cycle the counter reaches `TIMEOUT` counts as success.
- Outside the states listed above, all strobes are 0.
- Mux selects hold their DECODE-registered values until the next DECODE.

## Timing
- Reset
  - `state`=FETCH, wait counter=0.
  - Every output is 0. `alu_op` is 0.
  - `rst` mid-instruction aborts it. A store that has not completed never writes.
- Cycle counts, with `mem_ready` high on the first cycle of each access:
  - R-type and immediate ALU instructions: 4.
  - Loads: 5.
  - Stores: 4.
  - Branch, j, jr: 3.
  - jal, jalr: 4.
- Each memory stall adds one cycle per cycle that `mem_ready` is low.
- Decode-to-strobe latency: decoded fields appear one cycle after DECODE entry and are used from EXEC onward.

## Configuration
- `MC_CTRL_MDU_EN` defined
  - mult, multu, div, divu (funct 011000–011011) go EXEC→MDU_WAIT.
  - MDU_WAIT holds until `mdu_busy`=0, then goes to FETCH.
  - mfhi and mflo (010000, 010010) go EXEC→MDU_WAIT→WB.
  - The wait counter does not apply in MDU_WAIT.
- `MC_CTRL_MDU_EN` undefined
  - The `mdu_busy` port is absent.
  - Those funct codes raise `illegal`.
  - MDU_WAIT is unreachable.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - the ALU op constants (ADD=00001, SUB=00010, AND=00011, OR=00100, SLT=00101, SLTU=00110, XOR=01000, NOR=01001, SLL=01010, SRA=01011, LUI=01100, SRL=01101, SLLV=01110, SRLV=01111, BGEZ=10000, BLTZ=10001, BLEZ=10010, BGTZ=10011, SRAV=10100);
  - the `npc_op`, `length` and `reg_dst` encodings;
  - the opcode and funct constants.
- Sub-module `mc_ctrl_decode`: combinational instruction → field bundle plus an `illegal` flag.
- `mc_ctrl` owns the FSM, the registered field bundle and the wait counter.

## Test plan
- `instr`=0x00851020 (add), `mem_ready` always 1 → states 0,1,2,4. `reg_write`=1 only in cycle 4. `alu_op`=00001. `reg_dst`=01.
- lw 0x8C820004, `mem_ready` low for 3 cycles in MEM → 8 cycles total. `mem_read`=1 throughout MEM. `length`=000. `mem_to_reg`=01 in WB.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write`=1 with `npc_op`=01 in EXEC for the first only. Each takes 3 cycles.
- `TIMEOUT`=4, `mem_ready` held 0 in FETCH → `bus_err` pulse on cycle 4. No `pc_write`. Returns to FETCH with the counter cleared.
- Opcode 0x3F → `illegal` pulse in DECODE. No `reg_write` or `mem_write`. Next state FETCH.
- `rst` asserted during MEM of sw 0xAC820000 → next cycle state=FETCH, all outputs 0. `mem_write` never seen with `mem_ready`=1.
